// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Latency: the accept edge registers the address and data; regWrite is high for the next cycle only, then one forced low cycle.
// Backpressure: ready is low during the regWrite cycle; requesters hold until accepted. Pending-destination hazards raise stall.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic              stall,
    output logic              regWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data
);

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    // last_grant encoding: 1 means the load path won the previous contest
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [NREGS-1:0]  pending_q, pending_d;

    logic              can_accept;
    logic              grant_alu, grant_mem, accept;
    logic [ADDR_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_data;

    always_comb begin
        can_accept = (state_q != WRITE);
        grant_alu  = can_accept && alu_valid && (!mem_valid || last_grant_q == GRANT_MEM);
        grant_mem  = can_accept && mem_valid && !grant_alu;
        accept     = grant_alu || grant_mem;
        acc_reg    = grant_alu ? alu_reg  : mem_reg;
        acc_data   = grant_alu ? alu_data : mem_data;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        pending_d    = pending_q;

        if (accept) begin
            last_grant_d = grant_mem ? GRANT_MEM : GRANT_ALU;
            pending_d[acc_reg] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept && acc_reg != '0) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = GAP;
            end
            GAP: begin
                state_d = (accept && acc_reg != '0) ? WRITE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Register 0 completes the handshake but never reaches the register file
        if (accept && acc_reg != '0) begin
            regwrite_d   = 1'b1;
            write_reg_d  = acc_reg;
            write_data_d = acc_data;
        end

        // Set after clear so a same-cycle issue to the same register wins
        if (issue_valid && issue_reg != '0) begin
            pending_d[issue_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_MEM;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            pending_q    <= pending_d;
        end
    end

    assign alu_ready  = grant_alu;
    assign mem_ready  = grant_mem;
    assign stall      = pending_q[read_reg1] | pending_q[read_reg2];
    assign regWrite   = regwrite_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: hand-computed expectations for arbitration, pulse shaping and scoreboard.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid, mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic [ADDR_W-1:0] read_reg1, read_reg2;
    logic              stall;
    logic              regWrite;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .issue_valid(issue_valid),
        .issue_reg  (issue_reg),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .stall      (stall),
        .regWrite   (regWrite),
        .write_reg  (write_reg),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_reg = '0; alu_data = '0;
        mem_valid = 0; mem_reg = '0; mem_data = '0;
        issue_valid = 0; issue_reg = '0;
        read_reg1 = '0; read_reg2 = '0;

        // Reset state
        #12;
        check("rst_regWrite", regWrite, 0);
        check("rst_write_reg", write_reg, 0);
        check("rst_write_data", write_data, 0);
        check("rst_stall", stall, 0);
        step();
        rst_n = 1'b1;
        #1;

        // Single ALU write to r8
        alu_valid = 1; alu_reg = 8; alu_data = 32'h5;
        #1;
        check("t1_alu_ready", alu_ready, 1);
        check("t1_mem_ready", mem_ready, 0);
        step();
        alu_valid = 0;
        check("t1_c1_regWrite", regWrite, 1);
        check("t1_c1_write_reg", write_reg, 8);
        check("t1_c1_write_data", write_data, 5);
        step();
        check("t1_c2_regWrite", regWrite, 0);
        check("t1_c2_write_reg", write_reg, 8);
        step();

        // Load to r0: accepted, no pulse, outputs hold
        mem_valid = 1; mem_reg = 0; mem_data = 32'hFFFF_FFFF;
        #1;
        check("t3_mem_ready", mem_ready, 1);
        step();
        mem_valid = 0;
        check("t3_regWrite", regWrite, 0);
        check("t3_write_reg", write_reg, 8);
        check("t3_write_data", write_data, 5);
        alu_valid = 1; alu_reg = 9; alu_data = 32'h99;
        #1;
        check("t3_alu_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        check("t3_regWrite_r9", regWrite, 1);
        check("t3_write_reg_r9", write_reg, 9);
        check("t3_write_data_r9", write_data, 32'h99);
        step();
        step();

        // Scoreboard: issue r10, stall until the write is accepted
        issue_valid = 1; issue_reg = 10; read_reg1 = 10; read_reg2 = 0;
        #1;
        check("t4_no_bypass", stall, 0);
        step();
        issue_valid = 0;
        #1;
        check("t4_stall_set", stall, 1);
        step();
        check("t4_stall_held", stall, 1);
        alu_valid = 1; alu_reg = 10; alu_data = 32'hA;
        #1;
        check("t4_alu_ready", alu_ready, 1);
        check("t4_stall_accept_cycle", stall, 1);
        step();
        alu_valid = 0;
        #1;
        check("t4_stall_cleared", stall, 0);
        read_reg1 = 0;
        #1;
        check("t4_r0_no_stall", stall, 0);
        step();
        step();

        // Same-cycle set and clear on r12: set wins
        read_reg2 = 12;
        issue_valid = 1; issue_reg = 12;
        alu_valid = 1; alu_reg = 12; alu_data = 32'hC;
        #1;
        check("t5_alu_ready", alu_ready, 1);
        step();
        issue_valid = 0; alu_valid = 0;
        #1;
        check("t5_stall", stall, 1);
        check("t5_regWrite", regWrite, 1);
        check("t5_write_reg", write_reg, 12);
        step();
        step();

        // Async reset during WRITE; r12 is still pending going in
        alu_valid = 1; alu_reg = 5; alu_data = 32'h55;
        step();
        alu_valid = 0;
        check("t6_regWrite_pre", regWrite, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_regWrite_async", regWrite, 0);
        check("t6_write_reg_async", write_reg, 0);
        check("t6_write_data_async", write_data, 0);
        #1 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = i[ADDR_W-1:0];
            read_reg2 = i[ADDR_W-1:0];
            #1;
            check($sformatf("t6_stall_r%0d", i), stall, 0);
        end
        alu_valid = 1; alu_reg = 3; mem_valid = 1; mem_reg = 4;
        #1;
        check("t6_first_alu_ready", alu_ready, 1);
        check("t6_first_mem_ready", mem_ready, 0);
        alu_valid = 0; mem_valid = 0;
        read_reg1 = 0; read_reg2 = 0;

        // Both requesters held from reset: ALU, MEM, ALU, MEM
        do_reset();
        alu_valid = 1; alu_reg = 3; alu_data = 32'h33;
        mem_valid = 1; mem_reg = 4; mem_data = 32'h44;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                check($sformatf("t2_k%0d_alu_ready", k), alu_ready, (k % 4 == 0) ? 1 : 0);
                check($sformatf("t2_k%0d_mem_ready", k), mem_ready, (k % 4 == 2) ? 1 : 0);
                check($sformatf("t2_k%0d_regWrite", k), regWrite, 0);
            end else begin
                check($sformatf("t2_k%0d_alu_ready", k), alu_ready, 0);
                check($sformatf("t2_k%0d_mem_ready", k), mem_ready, 0);
                check($sformatf("t2_k%0d_regWrite", k), regWrite, 1);
                check($sformatf("t2_k%0d_write_reg", k), write_reg, (k % 4 == 1) ? 3 : 4);
                check($sformatf("t2_k%0d_write_data", k), write_data, (k % 4 == 1) ? 32'h33 : 32'h44);
            end
            step();
        end
        alu_valid = 0; mem_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
